// File: rtl/bid_pkg.sv
// Shared types for the bid controller host sequencer: opcodes, error codes, FSM states.
// The optional watchdog is enabled with the BIDSEQ_WDOG_EN macro.
package bid_pkg;

  typedef enum logic [3:0] {
    OP_NOP         = 4'd0,
    OP_UNLOCK      = 4'd1,
    OP_LOCK        = 4'd2,
    OP_LOAD_X      = 4'd3,
    OP_LOAD_Y      = 4'd4,
    OP_LOAD_Z      = 4'd5,
    OP_SET_COST    = 4'd6,
    OP_SET_TIMER   = 4'd7,
    OP_ROUND_START = 4'd8
  } bid_op_e;

  typedef enum logic [1:0] {
    SEQ_ERR_NONE = 2'd0,
    SEQ_ERR_CTRL = 2'd1,
    SEQ_ERR_WDOG = 2'd2
  } seq_err_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_UNLOCK,
    ST_CFG,
    ST_LOCK,
    ST_START,
    ST_WAIT_RND,
    ST_CAPTURE,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_WAIT_LO,
    ISS_WAIT_HI
  } iss_state_e;

  typedef struct packed {
    logic [31:0] key;
    logic [31:0] credit_x;
    logic [31:0] credit_y;
    logic [31:0] credit_z;
    logic [31:0] bid_cost;
    logic [31:0] round_time;
  } op_regs_t;

  localparam logic [2:0] CFG_LAST = 3'd4;

  // Configuration commands issued between UNLOCK and LOCK, in order.
  function automatic bid_op_e cfg_op(input logic [2:0] idx);
    case (idx)
      3'd0:    return OP_LOAD_X;
      3'd1:    return OP_LOAD_Y;
      3'd2:    return OP_LOAD_Z;
      3'd3:    return OP_SET_COST;
      default: return OP_SET_TIMER;
    endcase
  endfunction

endpackage

// File: rtl/bid_cmd_issuer.sv
// Single-command handshake with the bid controller: strobe, wait ready low, wait ready high.
// With BIDSEQ_WDOG_EN defined, a watchdog bounds every wait, including the external round wait.
module bid_cmd_issuer
  import bid_pkg::*;
#(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  bid_op_e     op,
  input  logic [31:0] data,
  input  logic        ext_wait,
  input  logic        ext_event,
  input  logic        ready,
  input  logic [2:0]  err,
  output logic [3:0]  C_op,
  output logic [31:0] C_data,
  output logic        C_start,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic        cmd_timeout
);

  iss_state_e state, state_d;
  logic       launch;

  assign launch = (state == ISS_IDLE) && req && ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state;
    cmd_done = 1'b0;
    cmd_err  = 1'b0;
    case (state)
      ISS_IDLE:    if (launch) state_d = ISS_WAIT_LO;
      ISS_WAIT_LO: begin
        if (!ready)           state_d = ISS_WAIT_HI;
        else if (cmd_timeout) state_d = ISS_IDLE;
      end
      ISS_WAIT_HI: begin
        if (ready) begin
          state_d  = ISS_IDLE;
          cmd_done = (err == 3'd0);
          cmd_err  = (err != 3'd0);
        end else if (cmd_timeout) begin
          state_d = ISS_IDLE;
        end
      end
      default:     state_d = ISS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ISS_IDLE;
      C_start <= 1'b0;
      C_op    <= 4'd0;
      C_data  <= 32'd0;
    end else begin
      state   <= state_d;
      C_start <= launch;
      if (launch) begin
        C_op   <= op;
        C_data <= data;
      end
    end
  end

`ifdef BIDSEQ_WDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            wd_event;

  always_comb begin
    wd_active = (state != ISS_IDLE) || ext_wait;
    case (state)
      ISS_WAIT_LO: wd_event = !ready;
      ISS_WAIT_HI: wd_event = ready;
      default:     wd_event = ext_event;
    endcase
  end

  // Counts cycles spent waiting for the current event; fires on the last allowed cycle.
  assign cmd_timeout = wd_active && !wd_event && (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 wd_cnt <= '0;
    else if (!wd_active || wd_event || cmd_timeout) wd_cnt <= '0;
    else                                          wd_cnt <= wd_cnt + WD_W'(1);
  end
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  logic unused_wdog_inputs;
  assign unused_wdog_inputs = ext_wait ^ ext_event;
  assign cmd_timeout        = 1'b0;
`endif

endmodule

// File: rtl/bid_round_sequencer.sv
// Host-side sequencer: configures the bid controller on `go`, then runs num_rounds rounds.
// Optional watchdog via BIDSEQ_WDOG_EN (seq_err = 2 on timeout).
module bid_round_sequencer
  import bid_pkg::*;
#(
  parameter int WDOG_CYCLES  = 1024,
  parameter int MAX_ROUNDS_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    go,
  input  logic                    abort,
  input  logic [31:0]             key,
  input  logic [31:0]             credit_x,
  input  logic [31:0]             credit_y,
  input  logic [31:0]             credit_z,
  input  logic [31:0]             bid_cost,
  input  logic [31:0]             round_time,
  input  logic [MAX_ROUNDS_W-1:0] num_rounds,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              seq_err,
  output logic [2:0]              ctrl_err,
  output logic [MAX_ROUNDS_W-1:0] rounds_done,
  output logic [31:0]             last_max_bid,
  output logic [2:0]              last_win,
  output logic [3:0]              C_op,
  output logic [31:0]             C_data,
  output logic                    C_start,
  input  logic                    ready,
  input  logic                    roundOver,
  input  logic [2:0]              err,
  input  logic [31:0]             maxBid,
  input  logic                    X_win,
  input  logic                    Y_win,
  input  logic                    Z_win
);

  seq_state_e              state, state_d;
  op_regs_t                ops_q;
  logic [MAX_ROUNDS_W-1:0] num_rounds_q;
  logic [2:0]              cfg_idx;
  logic                    abort_q, abort_seen;
  seq_err_e                seq_err_q;

  logic        iss_req;
  bid_op_e     iss_op;
  logic [31:0] iss_data;
  logic        cmd_done, cmd_err, cmd_timeout;

  assign busy       = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign done       = (state == ST_DONE);
  assign seq_err    = seq_err_q;
  assign abort_seen = abort | abort_q;

  bid_cmd_issuer #(.WDOG_CYCLES(WDOG_CYCLES)) u_issuer (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (iss_req),
    .op          (iss_op),
    .data        (iss_data),
    .ext_wait    (state == ST_WAIT_RND),
    .ext_event   (roundOver),
    .ready       (ready),
    .err         (err),
    .C_op        (C_op),
    .C_data      (C_data),
    .C_start     (C_start),
    .cmd_done    (cmd_done),
    .cmd_err     (cmd_err),
    .cmd_timeout (cmd_timeout)
  );

  always_comb begin
    iss_req  = 1'b0;
    iss_op   = OP_NOP;
    iss_data = 32'd0;
    case (state)
      ST_UNLOCK: begin
        iss_req  = 1'b1;
        iss_op   = OP_UNLOCK;
        iss_data = ops_q.key;
      end
      ST_CFG: begin
        iss_req = 1'b1;
        iss_op  = cfg_op(cfg_idx);
        case (cfg_idx)
          3'd0:    iss_data = ops_q.credit_x;
          3'd1:    iss_data = ops_q.credit_y;
          3'd2:    iss_data = ops_q.credit_z;
          3'd3:    iss_data = ops_q.bid_cost;
          default: iss_data = ops_q.round_time;
        endcase
      end
      ST_LOCK: begin
        iss_req = 1'b1;
        iss_op  = OP_LOCK;
      end
      ST_START: begin
        iss_req = 1'b1;
        iss_op  = OP_ROUND_START;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (go) state_d = ST_UNLOCK;
      ST_UNLOCK, ST_CFG, ST_LOCK, ST_START: begin
        if (cmd_err || cmd_timeout)                 state_d = ST_ERROR;
        else if (cmd_done && abort_seen)            state_d = ST_DONE;
        else if (cmd_done) begin
          if (state == ST_UNLOCK)                   state_d = ST_CFG;
          else if (state == ST_CFG)                 state_d = (cfg_idx == CFG_LAST) ? ST_LOCK : ST_CFG;
          else if (state == ST_LOCK)                state_d = (num_rounds_q == '0) ? ST_DONE : ST_START;
          else                                      state_d = ST_WAIT_RND;
        end
      end
      // A round result arriving together with abort is captured before stopping.
      ST_WAIT_RND: begin
        if (roundOver)        state_d = ST_CAPTURE;
        else if (cmd_timeout) state_d = ST_ERROR;
        else if (abort_seen)  state_d = ST_DONE;
      end
      ST_CAPTURE: state_d = (rounds_done == num_rounds_q || abort_seen) ? ST_DONE : ST_START;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the operand copy is plain flops, so it is reset with everything else.
      ops_q        <= '0;
      num_rounds_q <= '0;
      cfg_idx      <= 3'd0;
      abort_q      <= 1'b0;
      seq_err_q    <= SEQ_ERR_NONE;
      ctrl_err     <= 3'd0;
      rounds_done  <= '0;
      last_max_bid <= 32'd0;
      last_win     <= 3'd0;
    end else begin
      if (state == ST_IDLE && go) begin
        ops_q        <= '{key: key, credit_x: credit_x, credit_y: credit_y, credit_z: credit_z,
                          bid_cost: bid_cost, round_time: round_time};
        num_rounds_q <= num_rounds;
        cfg_idx      <= 3'd0;
        abort_q      <= 1'b0;
        seq_err_q    <= SEQ_ERR_NONE;
        ctrl_err     <= 3'd0;
        rounds_done  <= '0;
      end
      if (busy && abort) abort_q <= 1'b1;
      if (state == ST_CFG && cmd_done) cfg_idx <= cfg_idx + 3'd1;
      if (cmd_err) begin
        seq_err_q <= SEQ_ERR_CTRL;
        ctrl_err  <= err;
      end
      if (cmd_timeout) seq_err_q <= SEQ_ERR_WDOG;
      // Results are taken on the roundOver cycle itself, so a one-cycle valid window suffices.
      if (state == ST_WAIT_RND && roundOver) begin
        last_max_bid <= maxBid;
        last_win     <= {Z_win, Y_win, X_win};
        rounds_done  <= rounds_done + MAX_ROUNDS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bid_round_sequencer.sv
// Self-checking bench for bid_round_sequencer: randomized controller model plus command-list reference.
// Watchdog scenario runs only when BIDSEQ_WDOG_EN is defined.
module tb_bid_round_sequencer;

  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0, abort = 1'b0;
  logic [31:0]   key = '0, credit_x = '0, credit_y = '0, credit_z = '0, bid_cost = '0, round_time = '0;
  logic [RW-1:0] num_rounds = '0;
  logic          busy, done, C_start;
  logic [1:0]    seq_err;
  logic [2:0]    ctrl_err, last_win;
  logic [RW-1:0] rounds_done;
  logic [31:0]   last_max_bid, C_data;
  logic [3:0]    C_op;
  logic          ready = 1'b1, roundOver = 1'b0;
  logic [2:0]    err = '0;
  logic [31:0]   maxBid = '0;
  logic          X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;

  always #5 clk = ~clk;

  bid_round_sequencer #(.WDOG_CYCLES(16), .MAX_ROUNDS_W(RW)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .abort(abort), .key(key),
    .credit_x(credit_x), .credit_y(credit_y), .credit_z(credit_z),
    .bid_cost(bid_cost), .round_time(round_time), .num_rounds(num_rounds),
    .busy(busy), .done(done), .seq_err(seq_err), .ctrl_err(ctrl_err),
    .rounds_done(rounds_done), .last_max_bid(last_max_bid), .last_win(last_win),
    .C_op(C_op), .C_data(C_data), .C_start(C_start), .ready(ready),
    .roundOver(roundOver), .err(err), .maxBid(maxBid),
    .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller model knobs, written by the test sequence only.
  int          lat_fixed = 3;
  int          err_op = -1;
  logic [2:0]  err_val = '0;
  int          abort_round = 0;
  bit          withhold = 1'b0;
  logic [31:0] rnd_max [8];
  logic [2:0]  rnd_win [8];

  // Model state and command log, written by the model only.
  int          m_lat = 0, m_rnd = 0, m_ridx = 0, rise_cyc = 0;
  logic [3:0]  m_op = '0;
  logic [3:0]  log_op [$];
  logic [31:0] log_data [$];

  logic [31:0] exp_last_max = '0;
  logic [2:0]  exp_last_win = '0;

  // Behavioural bid controller: drops ready after a strobe, raises it later, ends rounds later still.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      ready = 1'b1; err = '0; roundOver = 1'b0; abort = 1'b0; m_lat = 0; m_rnd = 0; m_ridx = 0;
    end else begin
      roundOver = 1'b0;
      abort     = 1'b0;
      if (!busy) m_ridx = 0;
      if (C_start) begin
        check("cstart_with_ready", ready, 1'b1);
        log_op.push_back(C_op);
        log_data.push_back(C_data);
        m_op  = C_op;
        ready = 1'b0;
        err   = '0;
        m_lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      end else if (m_lat > 0) begin
        m_lat--;
        if (m_lat == 0) begin
          ready    = 1'b1;
          rise_cyc = cyc;
          err      = (err_op == int'(m_op)) ? err_val : 3'd0;
          if (m_op == 4'd8) m_rnd = $urandom_range(2, 6);
        end
      end else if (m_rnd > 0) begin
        m_rnd--;
        if (m_rnd == 0 && !withhold) begin
          roundOver = 1'b1;
          maxBid    = rnd_max[m_ridx];
          {Z_win, Y_win, X_win} = rnd_win[m_ridx];
          if (m_ridx + 1 == abort_round) abort = 1'b1;
          m_ridx++;
        end
      end
    end
  end

  task automatic rand_rounds();
    for (int k = 0; k < 8; k++) begin
      rnd_max[k] = $urandom;
      rnd_win[k] = 3'b001 << $urandom_range(0, 2);
    end
  endtask

  task automatic rand_host();
    key = $urandom; credit_x = $urandom; credit_y = $urandom; credit_z = $urandom;
    bid_cost = $urandom; round_time = $urandom;
  endtask

  // One full run; the expected command list and results come from the command-order rules.
  task automatic run_seq(input int n, input int eop, input logic [2:0] ev, input int ab,
                         input bit wh, input int lat);
    logic [3:0]  e_op [7];
    logic [31:0] e_data [7];
    int          base, len, exp_rounds, exp_done, exp_serr, done_cnt, fall_cyc;
    logic [2:0]  exp_cerr;
    bit          fell, fall_done;
    lat_fixed = lat; err_op = eop; err_val = ev; abort_round = ab; withhold = wh;
    rand_host();
    num_rounds = RW'(n);
    e_op   = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd2};
    e_data = '{key, credit_x, credit_y, credit_z, bid_cost, round_time, 32'd0};
    base   = log_op.size();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    check("go_busy", busy, 1'b1);
    check("go_no_start_yet", C_start, 1'b0);
    rand_host();
    num_rounds = RW'($urandom);
    @(negedge clk);
    check("go_to_cstart_latency", C_start, 1'b1);
    done_cnt = 0; fell = 1'b0; fall_done = 1'b0; fall_cyc = 0;
    for (int i = 0; i < 4000 && !fell; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!busy) begin
        fell = 1'b1; fall_cyc = cyc; fall_done = done;
      end
    end
    check("run_terminated", fell, 1'b1);
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end

    len = 7 + n; exp_rounds = n; exp_done = 1; exp_serr = 0; exp_cerr = '0;
    if (eop >= 0) begin
      for (int i = 6; i >= 0; i--) if (int'(e_op[i]) == eop) len = i + 1;
      exp_rounds = 0; exp_done = 0; exp_serr = 1; exp_cerr = ev;
    end else if (wh) begin
      len = 8; exp_rounds = 0; exp_done = 0; exp_serr = 2;
    end else if (ab >= 1 && ab <= n) begin
      len = 7 + ab; exp_rounds = ab;
    end
    for (int k = 0; k < exp_rounds; k++) begin
      exp_last_max = rnd_max[k];
      exp_last_win = rnd_win[k];
    end

    check("cmd_count", 64'(log_op.size() - base), 64'(len));
    for (int i = 0; i < len && base + i < log_op.size(); i++) begin
      check($sformatf("cmd%0d_op", i), log_op[base + i], (i < 7) ? e_op[i] : 4'd8);
      check($sformatf("cmd%0d_data", i), log_data[base + i], (i < 7) ? e_data[i] : 32'd0);
    end
    check("rounds_done", rounds_done, RW'(exp_rounds));
    check("last_max_bid", last_max_bid, exp_last_max);
    check("last_win", last_win, exp_last_win);
    check("seq_err", seq_err, 2'(exp_serr));
    check("ctrl_err", ctrl_err, exp_cerr);
    check("done_pulses", 64'(done_cnt), 64'(exp_done));
    if (eop >= 0)  check("err_busy_fall_delay", 64'(fall_cyc - rise_cyc), 64'd1);
    else if (wh)   check("wdog_busy_fall_delay", 64'(fall_cyc - rise_cyc), 64'd17);
    else           check("done_with_busy_fall", fall_done, 1'b1);
  endtask

  initial begin
    bit found;
    for (int k = 0; k < 8; k++) begin
      rnd_max[k] = '0; rnd_win[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cstart", C_start, 1'b0);
    check("rst_cop", C_op, 4'd0);
    check("rst_seq_err", seq_err, 2'd0);
    check("rst_rounds_done", rounds_done, '0);
    check("rst_last_max_bid", last_max_bid, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Two rounds: Y wins 0x64, then Z wins 0xC8.
    rnd_max[0] = 32'h64; rnd_win[0] = 3'b010;
    rnd_max[1] = 32'hC8; rnd_win[1] = 3'b100;
    run_seq(2, -1, 3'd0, 0, 1'b0, 3);

    // Controller error on LOAD_Y.
    run_seq(3, 4, 3'd3, 0, 1'b0, 3);

    // Zero rounds: configure and lock only.
    rand_rounds();
    run_seq(0, -1, 3'd0, 0, 1'b0, 0);

    // Abort together with roundOver in round 1 of 3.
    rand_rounds();
    run_seq(3, -1, 3'd0, 1, 1'b0, 0);

    // Reset while SET_COST is being strobed.
    rand_rounds();
    lat_fixed = 2; err_op = -1; abort_round = 0; withhold = 1'b0;
    rand_host();
    num_rounds = RW'(3);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (C_start && C_op == 4'd6) found = 1'b1;
    end
    check("reset_hit_set_cost", found, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_cstart", C_start, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_cop", C_op, 4'd0);
    check("async_rst_cdata", C_data, 32'd0);
    check("async_rst_last_max", last_max_bid, 32'd0);
    check("async_rst_last_win", last_win, 3'd0);
    exp_last_max = '0;
    exp_last_win = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rand_rounds();
    run_seq(1, -1, 3'd0, 0, 1'b0, 0);

`ifdef BIDSEQ_WDOG_EN
    // Round result withheld: watchdog fires 16 cycles into WAIT_RND.
    run_seq(2, -1, 3'd0, 0, 1'b1, 2);
`endif

    // Randomized runs: normal, aborted and failing configurations.
    for (int it = 0; it < 6; it++) begin
      rand_rounds();
      if (it % 3 == 2)
        run_seq(int'($urandom_range(1, 4)), int'($urandom_range(3, 7)),
                3'($urandom_range(1, 7)), 0, 1'b0, 0);
      else
        run_seq(int'($urandom_range(1, 4)), -1, 3'd0, int'($urandom_range(0, 4)), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bid_round_sequencer.md
# bid_round_sequencer

Host-side sequencer for the bid controller's command port (C_op/C_data/C_start, ready, roundOver). On one `go` pulse it unlocks the controller, loads the three bidder credits and the bid parameters, and locks the configuration. It then runs a programmed number of bid rounds, capturing maxBid and the winner after each round. It sits between the system host and the bid controller and replaces hand-issued opcode sequences.

## Interface
Parameters:
- `WDOG_CYCLES`, default 1024: maximum cycles to wait for `roundOver` after a round is started.
- `MAX_ROUNDS_W`, default 8: width of the round counter.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `go`  in  1  start pulse; ignored while `busy`.
- `abort`  in  1  stop at the next command boundary and go to DONE.
- `key`  in  32  unlock key.
- `credit_x`, `credit_y`, `credit_z`  in  32  starting balances.
- `bid_cost`  in  32  per-bid charge.
- `round_time`  in  32  round timer value.
- `num_rounds`  in  MAX_ROUNDS_W  rounds to run.
- `busy`  out  1  high from the cycle after `go` until DONE or ERROR.
- `done`  out  1  one-cycle pulse on completion or abort.
- `seq_err`  out  2  0 none, 1 controller error, 2 watchdog timeout; held until the next `go`.
- `ctrl_err`  out  3  controller `err` captured at failure.
- `rounds_done`  out  MAX_ROUNDS_W  completed rounds.
- `last_max_bid`  out  32  maxBid from the last round.
- `last_win`  out  3  {Z_win, Y_win, X_win} from the last round.
- `C_op`  out  4  controller opcode.
- `C_data`  out  32  controller operand.
- `C_start`  out  1  command strobe.
- `ready`  in  1  controller idle/accepting.
- `roundOver`  in  1  controller round-complete pulse.
- `err`  in  3  controller error code, valid when `ready` rises.
- `maxBid`  in  32  winning amount.
- `X_win`, `Y_win`, `Z_win`  in  1  winner flags.

## Operation
- Command order: UNLOCK(key), LOAD_X(credit_x), LOAD_Y(credit_y), LOAD_Z(credit_z), SET_COST(bid_cost), SET_TIMER(round_time), LOCK(0). This is followed by `num_rounds` × ROUND_START(0).
- States: IDLE → UNLOCK → CFG (index 0..4) → LOCK → START → WAIT_RND → CAPTURE → (START if rounds remain, else DONE) → IDLE. Any state can go to ERROR, and ERROR returns to IDLE.
- Command handshake:
  - Drive `C_op`/`C_data` and pulse `C_start` for one cycle, only in a cycle with `ready`=1.
  - Then wait for `ready`=0 followed by `ready`=1.
  - Sample `err` on the `ready` rising edge. A nonzero value sets `seq_err`=1, latches `ctrl_err`, and moves the FSM to ERROR.
- Operands: all host inputs are registered on `go` and used from the registered copy, so host changes during `busy` have no effect.
- Round handling:
  - WAIT_RND waits for `roundOver`.
  - CAPTURE latches `maxBid` and the win flags, increments `rounds_done`, and takes 1 cycle.
- `num_rounds`=0: configuration and LOCK are performed, then DONE with `rounds_done`=0.
- `abort`: sampled at each command boundary and in WAIT_RND. It ends the run in DONE with `seq_err` unchanged. An in-flight handshake always completes first.
- Simultaneous `roundOver` and `abort` in WAIT_RND: capture first, then DONE.
- `go` with `busy`=1: ignored.

## Timing
- Reset values: all outputs 0 and FSM in IDLE. `C_start` drops asynchronously on reset, including mid-command.
- Latency: first `C_start` two cycles after `go` (register, then issue), provided `ready`=1.
- `C_op`/`C_data` are stable from the `C_start` cycle until `ready` falls.
- Back-to-back commands: the next `C_start` comes no earlier than the cycle after the `ready` rise.
- `done` asserts the cycle after the final CAPTURE, or after LOCK completes when `num_rounds`=0. `busy` falls in the same cycle.
- ERROR: one cycle, then IDLE. `done` is not pulsed; `seq_err` stays valid.

## Configuration
- `BIDSEQ_WDOG_EN` defined:
  - WAIT_RND and each handshake wait carry a counter.
  - After `WDOG_CYCLES` cycles without the awaited event, the FSM moves to ERROR with `seq_err`=2.
- `BIDSEQ_WDOG_EN` undefined: no counter, unbounded waits, and `seq_err` never equals 2.

## Structure
- Shared package `bid_pkg`:
  - opcode enum (NOP=0, UNLOCK=1, LOCK=2, LOAD_X=3, LOAD_Y=4, LOAD_Z=5, SET_COST=6, SET_TIMER=7, ROUND_START=8);
  - `seq_err` codes;
  - FSM state enum.
- One sub-module, `bid_cmd_issuer`, owns the single-command handshake and the watchdog. Its interface is: request with op/data, `ready` input, then a `cmd_done`, `cmd_err` or `cmd_timeout` pulse. The top-level FSM sequences commands through it.

## Test plan
- `go`, `num_rounds`=2, `ready` model returns in 3 cycles, rounds end with maxBid 0x64 then 0xC8 (Y, then Z wins) → ops 1,3,4,5,6,7,2,8,8 in order; `rounds_done`=2; `last_max_bid`=0xC8; `last_win`=3'b100; one `done` pulse.
- Controller returns `err`=3'd3 on LOAD_Y → no further `C_start`; `seq_err`=1; `ctrl_err`=3; `busy` low 1 cycle later; no `done`.
- With `BIDSEQ_WDOG_EN`, `WDOG_CYCLES`=16, `roundOver` withheld → ERROR with `seq_err`=2 exactly 16 cycles into WAIT_RND.
- `num_rounds`=0 → seven commands ending with LOCK, no ROUND_START; `done` pulses and `rounds_done`=0.
- `abort` asserted with `roundOver` in the same cycle during round 1 of 3 → capture occurs; `rounds_done`=1; `done` pulses; no further ROUND_START.
- `reset_n` low while `C_start`=1 during SET_COST → all outputs 0 immediately; a following `go` restarts from UNLOCK.
